// File: rtl/dmem_arbiter_if.sv
// Bus between the two requesters, the arbiter and the single-port data memory.
interface dmem_arbiter_if #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 5
);
  logic                 a_req, a_we, a_ack;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [DATA_SIZE-1:0] a_wdata, a_rdata;
  logic                 b_req, b_we, b_ack;
  logic [ADDR_SIZE-1:0] b_addr;
  logic [DATA_SIZE-1:0] b_wdata, b_rdata;
  logic                 mem_w;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata, mem_rdata;

  // Arbiter side
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata, mem_w, mem_addr, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata, mem_w, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// One transaction per 3 cycles: IDLE (grant+latch) -> ACCESS (mem op) -> RESP (ack).
module dmem_arbiter #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_SIZE  = 5,
  parameter int FIXED_PRIO = 0
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]                 state;
  logic                       last_b, gnt_b, pick_b;
  logic                       lat_we;
  logic [ADDR_SIZE-1:0]       lat_addr;
  logic [DATA_SIZE-1:0]       lat_wdata;
  logic [1:0][DATA_SIZE-1:0]  rdata_q;

  // On a tie, round-robin favours whichever port was not granted last.
  always_comb begin
    pick_b = bus.b_req;
    if (bus.a_req && bus.b_req)
      pick_b = (FIXED_PRIO != 0) ? 1'b0 : !last_b;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      gnt_b     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.a_req || bus.b_req) begin
          gnt_b     <= pick_b;
          last_b    <= pick_b;
          lat_we    <= pick_b ? bus.b_we    : bus.a_we;
          lat_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
          lat_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
          state     <= ACCESS;
        end
        ACCESS: begin
          rdata_q[gnt_b] <= bus.mem_rdata;
          state          <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // mem_w decodes from state so an async reset mid-ACCESS kills the write at once.
  assign bus.mem_w     = (state == ACCESS) && lat_we;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.a_ack     = (state == RESP) && !gnt_b;
  assign bus.b_ack     = (state == RESP) &&  gnt_b;
  assign bus.a_rdata   = rdata_q[0];
  assign bus.b_rdata   = rdata_q[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin instance for most cases, fixed-priority instance for priority hold.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_SIZE(8), .ADDR_SIZE(5)) if_rr ();
  dmem_arbiter_if #(.DATA_SIZE(8), .ADDR_SIZE(5)) if_fp ();

  dmem_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(5), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst), .bus(if_rr));
  dmem_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(5), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst), .bus(if_fp));

  // Memory models: preloaded mem[i]=i once, independent of the arbiter reset.
  logic [7:0] mem_rr [32];
  logic [7:0] mem_fp [32];
  always @(posedge clk or posedge mem_init) begin
    if (mem_init) for (int i = 0; i < 32; i++) begin mem_rr[i] <= 8'(i); mem_fp[i] <= 8'(i); end
    else begin
      if (if_rr.mem_w) mem_rr[if_rr.mem_addr] <= if_rr.mem_wdata;
      if (if_fp.mem_w) mem_fp[if_fp.mem_addr] <= if_fp.mem_wdata;
    end
  end
  assign if_rr.mem_rdata = mem_rr[if_rr.mem_addr];
  assign if_fp.mem_rdata = mem_fp[if_fp.mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Full request on the round-robin instance, bounded wait for ack.
  task automatic xact_rr(input bit pb, input bit we, input logic [4:0] addr,
                         input logic [7:0] wd, output logic [7:0] rd);
    bit got = 1'b0;
    rd = 8'h00;
    if (pb) begin if_rr.b_req = 1; if_rr.b_we = we; if_rr.b_addr = addr; if_rr.b_wdata = wd; end
    else    begin if_rr.a_req = 1; if_rr.a_we = we; if_rr.a_addr = addr; if_rr.a_wdata = wd; end
    for (int n = 0; n < 10 && !got; n++) begin
      tick();
      if (pb ? if_rr.b_ack : if_rr.a_ack) begin
        got = 1'b1;
        rd  = pb ? if_rr.b_rdata : if_rr.a_rdata;
      end
    end
    if_rr.a_req = 0; if_rr.b_req = 0;
    if (!got) chk("xact ack timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit         who [4];
    int         cyc [4];
    int         k, na, nb;
    bit         got;

    mem_init = 1; rst = 1;
    if_rr.a_req = 0; if_rr.a_we = 0; if_rr.a_addr = 0; if_rr.a_wdata = 0;
    if_rr.b_req = 0; if_rr.b_we = 0; if_rr.b_addr = 0; if_rr.b_wdata = 0;
    if_fp.a_req = 0; if_fp.a_we = 0; if_fp.a_addr = 0; if_fp.a_wdata = 0;
    if_fp.b_req = 0; if_fp.b_we = 0; if_fp.b_addr = 0; if_fp.b_wdata = 0;
    #2 mem_init = 0;
    tick(); tick();
    chk("rst a_ack",     32'(if_rr.a_ack),     0);
    chk("rst b_ack",     32'(if_rr.b_ack),     0);
    chk("rst mem_w",     32'(if_rr.mem_w),     0);
    chk("rst mem_addr",  32'(if_rr.mem_addr),  0);
    chk("rst mem_wdata", 32'(if_rr.mem_wdata), 0);
    chk("rst a_rdata",   32'(if_rr.a_rdata),   0);
    chk("rst b_rdata",   32'(if_rr.b_rdata),   0);
    rst = 0;

    // Round-robin tie straight after reset: A first, then alternate.
    if_rr.a_addr = 5'd1; if_rr.b_addr = 5'd2;
    if_rr.a_req = 1; if_rr.b_req = 1;
    k = 0;
    for (int t = 1; t <= 11; t++) begin
      tick();
      chk("rr ack exclusive", 32'(if_rr.a_ack & if_rr.b_ack), 0);
      if (if_rr.a_ack && k < 4) begin who[k] = 0; cyc[k] = t; k++; end
      if (if_rr.b_ack && k < 4) begin who[k] = 1; cyc[k] = t; k++; end
    end
    if_rr.a_req = 0; if_rr.b_req = 0;
    chk("rr grant count", 32'(k), 4);
    for (int i = 0; i < 4 && i < k; i++) begin
      chk("rr grant order", 32'(who[i]), 32'(i % 2));
      if (i > 0) chk("rr ack spacing", 32'(cyc[i] - cyc[i-1]), 3);
    end
    chk("rr a_rdata", 32'(if_rr.a_rdata), 32'h01);
    chk("rr b_rdata", 32'(if_rr.b_rdata), 32'h02);
    tick();

    // A reads addr 5: ACCESS one edge after sampling, ack on the next.
    if_rr.a_req = 1; if_rr.a_we = 0; if_rr.a_addr = 5'd5;
    tick();
    chk("rd5 access addr", 32'(if_rr.mem_addr), 5);
    chk("rd5 access mem_w", 32'(if_rr.mem_w), 0);
    chk("rd5 early ack", 32'(if_rr.a_ack), 0);
    tick();
    chk("rd5 a_ack", 32'(if_rr.a_ack), 1);
    chk("rd5 b_ack", 32'(if_rr.b_ack), 0);
    chk("rd5 a_rdata", 32'(if_rr.a_rdata), 32'h05);
    if_rr.a_req = 0;
    tick();
    chk("rd5 ack pulse", 32'(if_rr.a_ack), 0);

    // B writes A5 to addr 3, then A reads it back.
    if_rr.b_req = 1; if_rr.b_we = 1; if_rr.b_addr = 5'd3; if_rr.b_wdata = 8'hA5;
    tick();
    chk("wr3 mem_w", 32'(if_rr.mem_w), 1);
    chk("wr3 mem_addr", 32'(if_rr.mem_addr), 3);
    chk("wr3 mem_wdata", 32'(if_rr.mem_wdata), 32'hA5);
    tick();
    chk("wr3 mem_w one cycle", 32'(if_rr.mem_w), 0);
    chk("wr3 b_ack", 32'(if_rr.b_ack), 1);
    chk("wr3 a_ack", 32'(if_rr.a_ack), 0);
    if_rr.b_req = 0; if_rr.b_we = 0;
    xact_rr(1'b0, 1'b0, 5'd3, 8'h00, rd);
    chk("rd3 after write", 32'(rd), 32'hA5);
    tick();

    // Fixed priority: A monopolises while held; B served once A drops.
    if_fp.a_addr = 5'd4; if_fp.b_addr = 5'd6;
    if_fp.a_req = 1; if_fp.b_req = 1;
    na = 0; nb = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (if_fp.a_ack) na++;
      if (if_fp.b_ack) nb++;
    end
    chk("fp a grants", 32'(na), 3);
    chk("fp b grants", 32'(nb), 0);
    chk("fp a_rdata", 32'(if_fp.a_rdata), 32'h04);
    if_fp.a_req = 0;
    got = 0;
    for (int t = 0; t < 6 && !got; t++) begin
      tick();
      if (if_fp.b_ack) got = 1;
    end
    chk("fp b served", 32'(got), 1);
    chk("fp b_rdata", 32'(if_fp.b_rdata), 32'h06);
    if_fp.b_req = 0;
    tick();

    // Reset in the middle of a write ACCESS: no commit, outputs clear.
    if_rr.a_req = 1; if_rr.a_we = 1; if_rr.a_addr = 5'd9; if_rr.a_wdata = 8'h77;
    tick();
    chk("wr9 mem_w before rst", 32'(if_rr.mem_w), 1);
    #2 rst = 1;
    #1;
    chk("rst mid mem_w", 32'(if_rr.mem_w), 0);
    chk("rst mid mem_addr", 32'(if_rr.mem_addr), 0);
    chk("rst mid mem_wdata", 32'(if_rr.mem_wdata), 0);
    chk("rst mid a_rdata", 32'(if_rr.a_rdata), 0);
    chk("rst mid a_ack", 32'(if_rr.a_ack), 0);
    if_rr.a_req = 0; if_rr.a_we = 0;
    tick();
    rst = 0;
    xact_rr(1'b0, 1'b0, 5'd9, 8'h00, rd);
    chk("rd9 after aborted write", 32'(rd), 32'h09);
    tick();

    // Address change after latching is ignored.
    if_rr.a_req = 1; if_rr.a_we = 0; if_rr.a_addr = 5'd2;
    tick();
    if_rr.a_addr = 5'd7;
    #1;
    chk("latched mem_addr", 32'(if_rr.mem_addr), 2);
    tick();
    chk("latched a_ack", 32'(if_rr.a_ack), 1);
    chk("latched a_rdata", 32'(if_rr.a_rdata), 32'h02);
    if_rr.a_req = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
